noc_vc_input_buffer: RTL and testbench
======================================

// Module: noc_vc_input_buffer
// PURPOSE
//  Router input-port buffer, multi-VC successor of the single-queue NOC input buffer.
//  NUM_VC independent FIFO queues share one flat 1R1W flit RAM (vc*DEPTH + ptr); the link writes, the switch allocator reads.
//  Per-VC empty/full flags feed VC/switch allocation; registered read data carries its VC tag for credit return upstream.
// PARAMETERS
//  DATA_W  16  flit width in bits
//  DEPTH   8   entries per VC; power of 2, >=2
//  NUM_VC  2   virtual channels; power of 2, >=1 (VC_W = max(1,$clog2(NUM_VC)))
// PORTS
//  clk              in   1             clock, all logic on rising edge
//  reset            in   1             synchronous, active-high
//  buf_write_i      in   1             write request
//  buf_wvc_i        in   VC_W          target VC of write
//  buf_data_i       in   DATA_W        write flit
//  buf_read_i       in   1             read request
//  buf_rvc_i        in   VC_W          source VC of read
//  buf_empty_o      out  NUM_VC        per-VC empty flag
//  buf_full_o       out  NUM_VC        per-VC full flag
//  buf_valid_o      out  1             buf_data_o/buf_vc_o valid (one-cycle pulse per accepted read)
//  buf_data_o       out  DATA_W        read flit
//  buf_vc_o         out  VC_W          VC of read flit; upstream credit return
//  buf_ram_raddr_o  out  RAM_AW        RAM address of last accepted read (RAM_AW=$clog2(NUM_VC*DEPTH))
//  buf_ram_waddr_o  out  RAM_AW        RAM address of last accepted write
// BEHAVIOUR
//  - Reset: all VC rd/wr ptrs 0, buf_empty_o all 1, buf_full_o all 0, buf_valid_o 0,
//    buf_data_o 0, buf_vc_o 0, both ram addr outputs 0. RAM contents not cleared.
//  - Per-VC ptrs are $clog2(DEPTH)+1 bits (wrap bit). empty = (wr==rd); full = low bits equal, wrap bits differ.
//  - Write accepted iff buf_write_i && !buf_full_o[buf_wvc_i] (registered flag); flit stored, wr ptr++ next edge.
//    Write to full VC is dropped; no state changes.
//  - Read accepted iff buf_read_i && !buf_empty_o[buf_rvc_i] (registered flag); rd ptr++ next edge.
//    Latency 1: on the following cycle buf_valid_o=1, buf_data_o=flit, buf_vc_o=VC. Read of empty VC: buf_valid_o=0.
//  - buf_data_o/buf_vc_o hold their last value while buf_valid_o=0.
//  - Same cycle, same VC: decisions use pre-edge flags. Full VC: read accepted, write dropped.
//    Empty VC: write accepted, read rejected (no bypass). Otherwise both accepted, occupancy unchanged.
//  - Same cycle, different VCs: fully independent.
//  - Pointer wrap: low bits roll DEPTH-1 -> 0, wrap bit toggles; address = vc*DEPTH + low bits.
//  - Flags are registered state, valid from the cycle after the causing edge.
//  - Reset mid-operation: all queues emptied immediately; an in-flight read output is squashed (buf_valid_o=0).
//  - Out-of-range VC index (NUM_VC not power of 2 is illegal) cannot occur.
// CONFIGURATION
//  NOC_IB_ERR_EN defined: adds ports err_overflow_o [NUM_VC] and err_underflow_o [NUM_VC], sticky flags
//    set the cycle after a dropped write / rejected read on that VC, cleared only by reset. No datapath effect.
//  NOC_IB_ERR_EN undefined: ports absent; dropped writes and rejected reads are silent.
// STRUCTURE
//  noc_ib_pkg: DATA_W/DEPTH/NUM_VC defaults, VC_W/PTR_W/RAM_AW derivation functions, flit_t, vc_t, ptr_t typedefs.
//  noc_ib_ram: 1R1W RAM, synchronous write, registered read (supplies the 1-cycle read latency).
//  Top: per-VC pointer arrays, flag logic, accept logic, output registers, optional error flags.
// TESTING (defaults DATA_W=16, DEPTH=8, NUM_VC=2)
//  - Reset: reset=1 one cycle -> buf_empty_o=2'b11, buf_full_o=2'b00, buf_valid_o=0, addr outputs 0.
//  - Write 16'h8000 to VC0, read VC0 next cycle -> cycle after read: buf_valid_o=1, buf_data_o=16'h8000, buf_vc_o=0, empty[0]=1.
//  - 8 writes VC1 (16'h0101..16'h0108) -> full[1]=1, empty[0] unchanged; 9th write 16'hDEAD dropped; 8 reads return
//    0101..0108 in order, raddr 8..15; overflow err[1]=1 when NOC_IB_ERR_EN.
//  - Wrap: 5 writes/5 reads VC0, then 8 writes/8 reads -> data in order, waddr sequence 5,6,7,0,1,..., no false full/empty.
//  - Simultaneous: VC0 empty, write+read VC0 -> write only, valid=0 next cycle; VC0 full, write+read VC0 -> read only,
//    stays occupancy 7; write VC0 + read VC1 non-empty -> both accepted.
//  - Reset mid-stream: 3 flits in VC1, read issued, reset same cycle -> buf_valid_o=0, empty=2'b11; next read of VC1 rejected.

Source files
------------

// File: rtl/noc_ib_pkg.sv
// Shared defaults, width derivation helpers and flit/VC/pointer typedefs for
// the multi-VC router input buffer.
package noc_ib_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 8;
  localparam int NUM_VC_DEF = 2;

  // A single-VC build still carries a 1-bit VC tag.
  function automatic int vc_w_f(input int num_vc);
    return (num_vc > 1) ? $clog2(num_vc) : 1;
  endfunction

  // Low bits index the entry, the extra top bit separates full from empty.
  function automatic int ptr_w_f(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int ram_aw_f(input int num_vc, input int depth);
    return $clog2(num_vc * depth);
  endfunction

  typedef logic [DATA_W_DEF-1:0]            flit_t;
  typedef logic [vc_w_f(NUM_VC_DEF)-1:0]    vc_t;
  typedef logic [ptr_w_f(DEPTH_DEF)-1:0]    ptr_t;

endpackage

// File: rtl/noc_vc_input_buffer_if.sv
// Link/allocator-facing bundle of the VC input buffer. The master side is the
// upstream link plus switch allocator; the slave side is the buffer itself.
interface noc_vc_input_buffer_if
  #(parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int NUM_VC = 2);

  import noc_ib_pkg::*;

  localparam int VC_W   = vc_w_f(NUM_VC);
  localparam int RAM_AW = ram_aw_f(NUM_VC, DEPTH);

  logic                buf_write_i;
  logic [VC_W-1:0]     buf_wvc_i;
  logic [DATA_W-1:0]   buf_data_i;
  logic                buf_read_i;
  logic [VC_W-1:0]     buf_rvc_i;
  logic [NUM_VC-1:0]   buf_empty_o;
  logic [NUM_VC-1:0]   buf_full_o;
  logic                buf_valid_o;
  logic [DATA_W-1:0]   buf_data_o;
  logic [VC_W-1:0]     buf_vc_o;
  logic [RAM_AW-1:0]   buf_ram_raddr_o;
  logic [RAM_AW-1:0]   buf_ram_waddr_o;

  modport master (
    output buf_write_i, buf_wvc_i, buf_data_i, buf_read_i, buf_rvc_i,
    input  buf_empty_o, buf_full_o, buf_valid_o, buf_data_o, buf_vc_o,
           buf_ram_raddr_o, buf_ram_waddr_o
  );

  modport slave (
    input  buf_write_i, buf_wvc_i, buf_data_i, buf_read_i, buf_rvc_i,
    output buf_empty_o, buf_full_o, buf_valid_o, buf_data_o, buf_vc_o,
           buf_ram_raddr_o, buf_ram_waddr_o
  );

endinterface

// File: rtl/noc_ib_ram.sv
// Flat 1R1W flit RAM: synchronous write, registered read. The read register
// provides the one-cycle read latency of the buffer. Contents are never reset.
module noc_ib_ram
  #(parameter int DATA_W = 16,
    parameter int AW     = 4)
  (input  logic              clk,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o);

  localparam int WORDS = 1 << AW;

  logic [DATA_W-1:0] mem_q [WORDS];
  logic [DATA_W-1:0] rdata_q;

  // Storage write and registered read port.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/noc_vc_input_buffer.sv
// Multi-VC router input buffer: NUM_VC FIFOs sharing one flat flit RAM at
// address vc*DEPTH + pointer low bits. Registered per-VC empty/full flags,
// one-cycle read latency with the VC tag returned for upstream credits.
// Optional NOC_IB_ERR_EN adds sticky per-VC overflow/underflow flags.
module noc_vc_input_buffer
  import noc_ib_pkg::*;
  #(parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int NUM_VC = NUM_VC_DEF)
  (input  logic                  clk,
   input  logic                  reset,
   noc_vc_input_buffer_if.slave  bus
`ifdef NOC_IB_ERR_EN
   ,
   output logic [NUM_VC-1:0]     err_overflow_o,
   output logic [NUM_VC-1:0]     err_underflow_o
`endif
  );

  localparam int VC_W   = vc_w_f(NUM_VC);
  localparam int PTR_W  = ptr_w_f(DEPTH);
  localparam int LOW_W  = PTR_W - 1;
  localparam int RAM_AW = ram_aw_f(NUM_VC, DEPTH);

  logic [PTR_W-1:0]  wr_ptr_q [NUM_VC];
  logic [PTR_W-1:0]  wr_ptr_d [NUM_VC];
  logic [PTR_W-1:0]  rd_ptr_q [NUM_VC];
  logic [PTR_W-1:0]  rd_ptr_d [NUM_VC];
  logic [NUM_VC-1:0] empty_q, empty_d;
  logic [NUM_VC-1:0] full_q, full_d;
  logic              vld_q, vld_d;
  logic [VC_W-1:0]   vc_q, vc_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [RAM_AW-1:0] raddr_q, raddr_d;
  logic [RAM_AW-1:0] waddr_q, waddr_d;

  logic              wr_full, rd_empty;
  logic              wr_acc, rd_acc;
  logic [PTR_W-1:0]  wsel_ptr, rsel_ptr;
  logic [RAM_AW-1:0] waddr_c, raddr_c;
  logic [DATA_W-1:0] ram_rdata;

  // Select the addressed VC's pointer and flag, decide acceptance from the
  // registered flags and form the flat RAM addresses.
  always_comb begin
    wsel_ptr = '0;
    rsel_ptr = '0;
    wr_full  = 1'b0;
    rd_empty = 1'b0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (bus.buf_wvc_i == VC_W'(v)) begin
        wsel_ptr = wr_ptr_q[v];
        wr_full  = full_q[v];
      end
      if (bus.buf_rvc_i == VC_W'(v)) begin
        rsel_ptr = rd_ptr_q[v];
        rd_empty = empty_q[v];
      end
    end
    wr_acc  = bus.buf_write_i && !wr_full;
    rd_acc  = bus.buf_read_i && !rd_empty;
    waddr_c = RAM_AW'(int'(bus.buf_wvc_i) * DEPTH + int'(wsel_ptr[LOW_W-1:0]));
    raddr_c = RAM_AW'(int'(bus.buf_rvc_i) * DEPTH + int'(rsel_ptr[LOW_W-1:0]));
  end

  // Next pointers, flags derived from them, and output-side register updates.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    empty_d  = empty_q;
    full_d   = full_q;
    vld_d    = rd_acc;
    vc_d     = vc_q;
    hold_d   = hold_q;
    raddr_d  = raddr_q;
    waddr_d  = waddr_q;
    for (int v = 0; v < NUM_VC; v++) begin
      if (wr_acc && (bus.buf_wvc_i == VC_W'(v))) wr_ptr_d[v] = wr_ptr_q[v] + PTR_W'(1);
      if (rd_acc && (bus.buf_rvc_i == VC_W'(v))) rd_ptr_d[v] = rd_ptr_q[v] + PTR_W'(1);
      empty_d[v] = (wr_ptr_d[v] == rd_ptr_d[v]);
      full_d[v]  = (wr_ptr_d[v][LOW_W-1:0] == rd_ptr_d[v][LOW_W-1:0]) &&
                   (wr_ptr_d[v][PTR_W-1] != rd_ptr_d[v][PTR_W-1]);
    end
    if (rd_acc) begin
      vc_d    = bus.buf_rvc_i;
      raddr_d = raddr_c;
    end
    if (wr_acc) waddr_d = waddr_c;
    // Capture the flit being presented so it persists once valid drops.
    if (vld_q) hold_d = ram_rdata;
  end

  // State registers; reset empties every queue and squashes any in-flight read.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
      end
      empty_q <= '1;
      full_q  <= '0;
      vld_q   <= 1'b0;
      vc_q    <= '0;
      hold_q  <= '0;
      raddr_q <= '0;
      waddr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      vld_q    <= vld_d;
      vc_q     <= vc_d;
      hold_q   <= hold_d;
      raddr_q  <= raddr_d;
      waddr_q  <= waddr_d;
    end
  end

  noc_ib_ram #(.DATA_W(DATA_W), .AW(RAM_AW)) u_ram (
    .clk     (clk),
    .we_i    (wr_acc && !reset),
    .waddr_i (waddr_c),
    .wdata_i (bus.buf_data_i),
    .re_i    (rd_acc && !reset),
    .raddr_i (raddr_c),
    .rdata_o (ram_rdata)
  );

  assign bus.buf_empty_o     = empty_q;
  assign bus.buf_full_o      = full_q;
  assign bus.buf_valid_o     = vld_q;
  assign bus.buf_data_o      = vld_q ? ram_rdata : hold_q;
  assign bus.buf_vc_o        = vc_q;
  assign bus.buf_ram_raddr_o = raddr_q;
  assign bus.buf_ram_waddr_o = waddr_q;

`ifdef NOC_IB_ERR_EN
  logic [NUM_VC-1:0] ovf_q, ovf_d;
  logic [NUM_VC-1:0] udf_q, udf_d;

  // Sticky flags for writes dropped on a full VC and reads rejected on an empty VC.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    for (int v = 0; v < NUM_VC; v++) begin
      if (bus.buf_write_i && (bus.buf_wvc_i == VC_W'(v)) && full_q[v])  ovf_d[v] = 1'b1;
      if (bus.buf_read_i  && (bus.buf_rvc_i == VC_W'(v)) && empty_q[v]) udf_d[v] = 1'b1;
    end
  end

  // Error flag registers, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= '0;
      udf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign err_overflow_o  = ovf_q;
  assign err_underflow_o = udf_q;
`endif

endmodule

// File: tb/tb_noc_vc_input_buffer.sv
// Directed bench for noc_vc_input_buffer at DATA_W=16, DEPTH=8, NUM_VC=2.
// Error-flag checks are included when NOC_IB_ERR_EN is defined.
module tb_noc_vc_input_buffer;
  import noc_ib_pkg::*;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int NUM_VC = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  noc_vc_input_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_VC(NUM_VC)) bus ();

`ifdef NOC_IB_ERR_EN
  logic [NUM_VC-1:0] err_ovf, err_udf;
`endif

  noc_vc_input_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_VC(NUM_VC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef NOC_IB_ERR_EN
    ,
    .err_overflow_o  (err_ovf),
    .err_underflow_o (err_udf)
`endif
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic wvc, input flit_t wd,
                       input logic r, input logic rvc);
    bus.buf_write_i = w;
    bus.buf_wvc_i   = wvc;
    bus.buf_data_i  = wd;
    bus.buf_read_i  = r;
    bus.buf_rvc_i   = rvc;
  endtask

  task automatic cycle(input logic w, input logic wvc, input flit_t wd,
                       input logic r, input logic rvc);
    drive(w, wvc, wd, r, rvc);
    step();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);

    // Reset state
    do_reset();
    check_val("rst_empty", 32'(bus.buf_empty_o), 32'h3);
    check_val("rst_full",  32'(bus.buf_full_o),  32'h0);
    check_val("rst_valid", 32'(bus.buf_valid_o), 32'h0);
    check_val("rst_data",  32'(bus.buf_data_o),  32'h0);
    check_val("rst_vc",    32'(bus.buf_vc_o),    32'h0);
    check_val("rst_raddr", 32'(bus.buf_ram_raddr_o), 32'h0);
    check_val("rst_waddr", 32'(bus.buf_ram_waddr_o), 32'h0);

    // Single write then read, VC0
    cycle(1'b1, 1'b0, 16'h8000, 1'b0, 1'b0);
    check_val("w1_empty", 32'(bus.buf_empty_o), 32'h2);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check_val("r1_valid", 32'(bus.buf_valid_o), 32'h1);
    check_val("r1_data",  32'(bus.buf_data_o),  32'h8000);
    check_val("r1_vc",    32'(bus.buf_vc_o),    32'h0);
    check_val("r1_empty", 32'(bus.buf_empty_o), 32'h3);
    step();
    check_val("r1_vld_drop", 32'(bus.buf_valid_o), 32'h0);
    check_val("r1_hold",     32'(bus.buf_data_o),  32'h8000);

    // Fill VC1, overflow, drain
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b1, flit_t'(16'h0101 + i), 1'b0, 1'b0);
      check_val("fill_waddr", 32'(bus.buf_ram_waddr_o), 32'(8 + i));
    end
    check_val("fill_full",  32'(bus.buf_full_o),  32'h2);
    check_val("fill_empty", 32'(bus.buf_empty_o), 32'h1);
    cycle(1'b1, 1'b1, 16'hDEAD, 1'b0, 1'b0);
    check_val("ovf_full",  32'(bus.buf_full_o),      32'h2);
    check_val("ovf_waddr", 32'(bus.buf_ram_waddr_o), 32'd15);
`ifdef NOC_IB_ERR_EN
    check_val("ovf_err", 32'(err_ovf), 32'h2);
`endif
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
      check_val("drain_valid", 32'(bus.buf_valid_o),     32'h1);
      check_val("drain_data",  32'(bus.buf_data_o),      32'(16'h0101 + i));
      check_val("drain_vc",    32'(bus.buf_vc_o),        32'h1);
      check_val("drain_raddr", 32'(bus.buf_ram_raddr_o), 32'(8 + i));
    end
    check_val("drain_empty", 32'(bus.buf_empty_o), 32'h3);
    check_val("drain_full",  32'(bus.buf_full_o),  32'h0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check_val("udf_valid", 32'(bus.buf_valid_o), 32'h0);
    check_val("udf_hold",  32'(bus.buf_data_o),  32'h0108);
`ifdef NOC_IB_ERR_EN
    check_val("udf_err", 32'(err_udf), 32'h2);
`endif

    // Pointer wrap on VC0
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, flit_t'(16'h0500 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
      check_val("pre_data", 32'(bus.buf_data_o), 32'(16'h0500 + i));
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, flit_t'(16'h0A00 + i), 1'b0, 1'b0);
      check_val("wrap_waddr", 32'(bus.buf_ram_waddr_o), 32'((5 + i) % 8));
      check_val("wrap_full",  32'(bus.buf_full_o[0]),   32'(i == 7));
      check_val("wrap_nempty", 32'(bus.buf_empty_o[0]), 32'h0);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
      check_val("wrap_data",  32'(bus.buf_data_o),      32'(16'h0A00 + i));
      check_val("wrap_raddr", 32'(bus.buf_ram_raddr_o), 32'((5 + i) % 8));
      check_val("wrap_empty", 32'(bus.buf_empty_o[0]),  32'(i == 7));
      check_val("wrap_nfull", 32'(bus.buf_full_o[0]),   32'h0);
    end

    // Simultaneous write+read on empty VC0: write only
    cycle(1'b1, 1'b0, 16'hBEEF, 1'b1, 1'b0);
    check_val("se_valid", 32'(bus.buf_valid_o),     32'h0);
    check_val("se_empty", 32'(bus.buf_empty_o[0]),  32'h0);
    check_val("se_waddr", 32'(bus.buf_ram_waddr_o), 32'd5);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check_val("se_data", 32'(bus.buf_data_o), 32'hBEEF);

    // Simultaneous write+read on full VC0: read only
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, flit_t'(16'hC000 + i), 1'b0, 1'b0);
    check_val("sf_full0", 32'(bus.buf_full_o[0]), 32'h1);
    cycle(1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    check_val("sf_valid", 32'(bus.buf_valid_o),     32'h1);
    check_val("sf_data",  32'(bus.buf_data_o),      32'hC000);
    check_val("sf_full",  32'(bus.buf_full_o[0]),   32'h0);
    check_val("sf_waddr", 32'(bus.buf_ram_waddr_o), 32'd5);
    cycle(1'b1, 1'b0, 16'hC0FF, 1'b0, 1'b0);
    check_val("sf_refill", 32'(bus.buf_full_o[0]),   32'h1);
    check_val("sf_waddr2", 32'(bus.buf_ram_waddr_o), 32'd6);

    // Write VC0 + read non-empty VC1: both accepted
    cycle(1'b1, 1'b1, 16'h1111, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check_val("sd_pre", 32'(bus.buf_data_o), 32'hC001);
    cycle(1'b1, 1'b0, 16'h2222, 1'b1, 1'b1);
    check_val("sd_valid", 32'(bus.buf_valid_o),     32'h1);
    check_val("sd_data",  32'(bus.buf_data_o),      32'h1111);
    check_val("sd_vc",    32'(bus.buf_vc_o),        32'h1);
    check_val("sd_empty", 32'(bus.buf_empty_o),     32'h2);
    check_val("sd_full",  32'(bus.buf_full_o),      32'h1);
    check_val("sd_waddr", 32'(bus.buf_ram_waddr_o), 32'd7);
    check_val("sd_raddr", 32'(bus.buf_ram_raddr_o), 32'd8);

    // Reset mid-stream with a read in flight
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, flit_t'(16'h3001 + i), 1'b0, 1'b0);
    check_val("rm_pre_empty", 32'(bus.buf_empty_o), 32'h1);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check_val("rm_valid", 32'(bus.buf_valid_o), 32'h0);
    check_val("rm_empty", 32'(bus.buf_empty_o), 32'h3);
    check_val("rm_data",  32'(bus.buf_data_o),  32'h0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check_val("rm_rej_valid", 32'(bus.buf_valid_o), 32'h0);
    check_val("rm_rej_raddr", 32'(bus.buf_ram_raddr_o), 32'h0);
`ifdef NOC_IB_ERR_EN
    check_val("rm_udf", 32'(err_udf), 32'h2);
    check_val("rm_ovf", 32'(err_ovf), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
